// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared handshake state encoding for the CDC arbiter
package cdc_pkg;

   // IDLE: channel free. REQ: xfer_req high, waiting for ack rise.
   // DROP: xfer_req low, waiting for ack fall.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } hs_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// Ports:
//   req  in  NUM_REQ  request vector
//   last in  IDX_W    index granted most recently; search starts at last+1
//   gnt  out NUM_REQ  one-hot winner (zero when no request)
//   idx  out IDX_W    binary index of the winner
//   any  out 1        at least one request present
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   always_comb begin
      logic [IDX_W-1:0] pos;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      pos = '0;
      // Walk the ring starting just after the last winner; the first hit wins.
      for (int k = 1; k <= NUM_REQ; k++) begin
         pos = IDX_W'((int'(last) + k) % NUM_REQ);
         if (!any && req[pos]) begin
            any      = 1'b1;
            gnt[pos] = 1'b1;
            idx      = pos;
         end
      end
   end

endmodule

// File: rtl/cdc_hs_arbiter.sv
// rtl/cdc_hs_arbiter.sv - round-robin arbiter feeding one four-phase CDC handshake
// Ports:
//   clk_i        in  1               source-domain clock
//   rst_ni       in  1               asynchronous active-low reset
//   req_valid_i  in  NUM_REQ         per-requester request, held until accepted
//   req_data_i   in  NUM_REQ*DATA_W  per-requester payload, lane i at [i*DATA_W +: DATA_W]
//   req_ready_o  out NUM_REQ         one-hot accept strobe (combinational)
//   xfer_req_o   out 1               four-phase request to the synchronizer
//   xfer_data_o  out DATA_W          captured payload, stable while xfer_req_o is high
//   xfer_ack_i   in  1               four-phase ack, already synchronized to clk_i
//   grant_id_o   out IDX_W           index of the requester owning the channel
//   busy_o       out 1               high whenever the FSM is not idle
//   timeout_o    out 1               one-cycle pulse when a transfer is abandoned
module cdc_hs_arbiter
   import cdc_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int TO_CYC  = 64,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   output logic                      xfer_req_o,
   output logic [DATA_W-1:0]         xfer_data_o,
   input  logic                      xfer_ack_i,
   output logic [IDX_W-1:0]          grant_id_o,
   output logic                      busy_o,
   output logic                      timeout_o
);

   localparam int CNT_W = $clog2(TO_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYC - 1);

   hs_state_e            state_q, state_d;
   logic                 xfer_req_q;
   logic [DATA_W-1:0]    data_q;
   logic [IDX_W-1:0]     gid_q;
   logic [IDX_W-1:0]     last_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 to_q;
   logic                 to_d;
   logic                 accept;

   logic [NUM_REQ-1:0]   pick_gnt;
   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_any;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req  (req_valid_i),
      .last (last_q),
      .gnt  (pick_gnt),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      to_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A stale ack from an abandoned transfer blocks new grants.
            if (!xfer_ack_i && pick_any) begin
               accept  = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            // Ack is checked first so it wins over a same-cycle timeout.
            if (xfer_ack_i) begin
               state_d = ST_DROP;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_DROP;
               to_d    = 1'b1;
            end
         end
         ST_DROP: begin
            if (!xfer_ack_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Gated by reset so no strobe escapes while the registers are held.
   assign req_ready_o = (accept && rst_ni) ? pick_gnt : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         xfer_req_q <= 1'b0;
         data_q     <= '0;
         gid_q      <= '0;
         last_q     <= IDX_W'(NUM_REQ - 1);
         cnt_q      <= '0;
         to_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         xfer_req_q <= (state_d == ST_REQ);
         to_q       <= to_d;
         if (accept) begin
            data_q <= req_data_i[pick_idx*DATA_W +: DATA_W];
            gid_q  <= pick_idx;
         end
         // Rotation advances when the transfer completes, acked or abandoned.
         if (state_q == ST_REQ && state_d == ST_DROP) begin
            last_q <= gid_q;
         end
         if (accept) begin
            cnt_q <= '0;
         end else if (state_q == ST_REQ && state_d == ST_REQ) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign xfer_req_o  = xfer_req_q;
   assign xfer_data_o = data_q;
   assign grant_id_o  = gid_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign timeout_o   = to_q;

endmodule

// File: tb/tb_cdc_hs_arbiter.sv
// tb/tb_cdc_hs_arbiter.sv - self-checking bench for cdc_hs_arbiter
module tb_cdc_hs_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int TO = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     valid;
   logic [NR*DW-1:0]  data;
   logic              ack;
   logic [NR-1:0]     ready;
   logic              xreq;
   logic [DW-1:0]     xdata;
   logic [1:0]        gid;
   logic              busy;
   logic              tout;

   always #5 clk = ~clk;

   cdc_hs_arbiter #(
      .NUM_REQ (NR),
      .DATA_W  (DW),
      .TO_CYC  (TO)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (valid),
      .req_data_i  (data),
      .req_ready_o (ready),
      .xfer_req_o  (xreq),
      .xfer_data_o (xdata),
      .xfer_ack_i  (ack),
      .grant_id_o  (gid),
      .busy_o      (busy),
      .timeout_o   (tout)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: phase 0 idle, 1 requesting, 2 waiting for ack release.
   int            m_phase;
   int            m_last;
   int            m_gid;
   int            m_wait;
   logic [DW-1:0] m_data;
   logic          m_to;
   int            acc_w;

   // Ack responder knobs.
   int   up_dly;
   int   dn_dly;
   int   r_cnt;
   int   r_phase;
   logic idle_ack;

   int n;
   int exp_order [5] = '{0, 1, 2, 3, 0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_pick();
      int p;
      for (int k = 1; k <= NR; k++) begin
         p = (m_last + k) % NR;
         if (valid[p]) return p;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_last  = NR - 1;
      m_gid   = 0;
      m_wait  = 0;
      m_data  = '0;
      m_to    = 1'b0;
      r_phase = 0;
      r_cnt   = 0;
   endtask

   // One clock: check the combinational strobe, advance the model, check registers.
   task automatic cycle();
      int w;
      logic [NR-1:0] exp_rdy;
      w = (m_phase == 0 && ack == 1'b0) ? model_pick() : -1;
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      #1;
      chk("ready", 32'(ready), 32'(exp_rdy));
      m_to = 1'b0;
      case (m_phase)
         0: if (w >= 0) begin
               m_gid   = w;
               m_data  = data[w*DW +: DW];
               m_phase = 1;
               m_wait  = 0;
            end
         1: if (ack) begin
               m_phase = 2;
               m_last  = m_gid;
            end else if (m_wait == TO - 1) begin
               m_phase = 2;
               m_last  = m_gid;
               m_to    = 1'b1;
            end else begin
               m_wait++;
            end
         default: if (!ack) m_phase = 0;
      endcase
      acc_w = w;
      @(posedge clk);
      #1;
      if (w >= 0) valid[w] = 1'b0;
      chk("xfer_req", 32'(xreq), 32'(m_phase == 1));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("timeout", 32'(tout), 32'(m_to));
      chk("grant_id", 32'(gid), 32'(m_gid));
      chk("xfer_data", 32'(xdata), 32'(m_data));
   endtask

   task automatic resp_cycle();
      if (m_phase != r_phase) begin
         r_cnt   = 0;
         r_phase = m_phase;
      end
      if (m_phase == 1) begin
         if (r_cnt >= up_dly) ack = 1'b1;
         else begin ack = 1'b0; r_cnt++; end
      end else if (m_phase == 2) begin
         if (r_cnt >= dn_dly) ack = 1'b0;
         else begin ack = 1'b1; r_cnt++; end
      end else begin
         ack = idle_ack;
      end
      cycle();
   endtask

   task automatic wait_accept(input string tag);
      int k;
      k = 0;
      acc_w = -1;
      while (acc_w < 0 && k < 30) begin
         resp_cycle();
         k++;
      end
      chk(tag, 32'(acc_w >= 0), 32'd1);
   endtask

   task automatic finish_xfer(input string tag);
      int k;
      k = 0;
      while (m_phase != 0 && k < 40) begin
         resp_cycle();
         k++;
      end
      chk(tag, 32'(m_phase), 32'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      valid    = '1;
      data     = 32'h44332211;
      ack      = 1'b0;
      idle_ack = 1'b0;
      up_dly   = 0;
      dn_dly   = 0;
      model_reset();

      // Reset values, with every requester asking and ack low.
      #2;
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_xfer_req", 32'(xreq), 32'd0);
      chk("rst_data", 32'(xdata), 32'd0);
      chk("rst_gid", 32'(gid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_timeout", 32'(tout), 32'd0);
      valid = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single requester 2 with A5, ack three cycles after request rises.
      data   = 32'h00A50000;
      valid  = 4'b0100;
      up_dly = 3;
      dn_dly = 0;
      resp_cycle();
      chk("t031_accept", 32'(acc_w), 32'd2);
      chk("t031_gid", 32'(gid), 32'd2);
      chk("t031_data", 32'(xdata), 32'hA5);
      n = 0;
      while (m_phase != 0 && n < 20) begin
         resp_cycle();
         n++;
      end
      chk("t031_len", 32'(n), 32'd5);
      chk("t031_busy_end", 32'(busy), 32'd0);

      // All four held valid after reset, ack echoed two cycles late.
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      data   = 32'h44332211;
      up_dly = 2;
      dn_dly = 2;
      for (int i = 0; i < 5; i++) begin
         valid = '1;
         wait_accept("t032_wait");
         chk("t032_order", 32'(gid), 32'(exp_order[i]));
         finish_xfer("t032_done");
      end
      valid = '0;

      // No ack: timeout eight cycles after request rises, next index follows.
      data   = 32'h00005A00;
      valid  = 4'b0010;
      up_dly = 100;
      dn_dly = 0;
      wait_accept("t033_wait");
      chk("t033_gid", 32'(gid), 32'd1);
      n = 0;
      while (tout !== 1'b1 && n < 20) begin
         resp_cycle();
         n++;
      end
      chk("t033_latency", 32'(n), 32'd8);
      chk("t033_req_low", 32'(xreq), 32'd0);
      valid  = '1;
      up_dly = 1;
      wait_accept("t033_next_wait");
      chk("t033_next", 32'(gid), 32'd2);
      finish_xfer("t033_done");
      valid = '0;

      // Late ack held high in idle after a timeout blocks grants until it falls.
      valid  = 4'b0001;
      up_dly = 100;
      wait_accept("t034_wait");
      n = 0;
      while (tout !== 1'b1 && n < 20) begin
         resp_cycle();
         n++;
      end
      chk("t034_timeout", 32'(tout), 32'd1);
      valid = '0;
      ack   = 1'b0;
      cycle();
      ack   = 1'b1;
      valid = 4'b1001;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t034_stale", 32'(ready), 32'd0);
      end
      ack = 1'b0;
      cycle();
      chk("t034_first", 32'(acc_w), 32'd3);
      chk("t034_gid", 32'(gid), 32'd3);
      up_dly = 0;
      finish_xfer("t034_done");
      valid = '0;

      // Reset pulsed in the middle of a request.
      valid  = 4'b0100;
      up_dly = 100;
      wait_accept("t035_wait");
      resp_cycle();
      resp_cycle();
      chk("t035_in_req", 32'(xreq), 32'd1);
      rst_n = 1'b0;
      ack   = 1'b1;
      #1;
      chk("t035_req_async", 32'(xreq), 32'd0);
      chk("t035_busy", 32'(busy), 32'd0);
      chk("t035_gid", 32'(gid), 32'd0);
      chk("t035_data", 32'(xdata), 32'd0);
      chk("t035_timeout", 32'(tout), 32'd0);
      chk("t035_ready", 32'(ready), 32'd0);
      model_reset();
      valid = '1;
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cycle();
      cycle();
      ack = 1'b0;
      cycle();
      chk("t035_first", 32'(gid), 32'd0);
      up_dly = 2;
      finish_xfer("t035_done");
      valid = '0;

      // Ack rises on the last counted cycle: ack wins, no timeout.
      valid  = 4'b0010;
      up_dly = TO - 1;
      dn_dly = 1;
      wait_accept("t036_wait");
      n = 0;
      while (m_phase == 1 && n < 20) begin
         resp_cycle();
         n++;
      end
      chk("t036_len", 32'(n), 32'(TO));
      chk("t036_timeout", 32'(tout), 32'd0);
      chk("t036_busy", 32'(busy), 32'd1);
      chk("t036_req", 32'(xreq), 32'd0);
      finish_xfer("t036_done");
      valid = '0;

      // Randomized traffic, ack delays and stale acks against the model.
      up_dly = 1;
      dn_dly = 1;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) valid = valid | NR'($urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0) valid = valid & NR'($urandom_range(0, 15));
         data     = $urandom;
         idle_ack = ($urandom_range(0, 7) == 0);
         resp_cycle();
         if (acc_w >= 0) begin
            up_dly = $urandom_range(0, 9);
            dn_dly = $urandom_range(0, 3);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
